// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int unsigned ST_W          = 2;
    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder cell driven one bit per clock by the serial controller.
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_c,
    output logic cout_c
);

    // Sum is odd parity of the three inputs; carry is their majority.
    assign s_c    = a_i ^ b_i ^ cin_i;
    assign cout_c = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : serial_fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: captures A/B/Cin on start, feeds one bit per clock
// LSB-first through a single full adder cell, and publishes S/Cout as a parallel word.
// Optional build macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag (ovf_output).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_input,
    input  logic             rst_input,
    input  logic             start_input,
    input  logic [WIDTH-1:0] A_input,
    input  logic [WIDTH-1:0] B_input,
    input  logic             Cin_input,
    output logic             busy_output,
    output logic             done_output,
    output logic [WIDTH-1:0] S_output,
    output logic             Cout_output
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_output
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               sum_c;
    logic               fa_cout_c;
    logic [WIDTH-1:0]   res_shift_c;

    // Single full adder processes the current LSBs and the stored carry.
    serial_fa_cell u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .s_c    (sum_c),
        .cout_c (fa_cout_c)
    );

    // Result word with this cycle's sum bit pushed in at the MSB (valid for WIDTH=1 too).
    assign res_shift_c = WIDTH'({sum_c, res_q} >> 1);

    // Next-state and datapath: capture in IDLE, one bit per clock in SHIFT, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_input) begin
                    a_d     = A_input;
                    b_d     = B_input;
                    carry_d = Cin_input;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                carry_d = fa_cout_c;
                res_d   = res_shift_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    s_d     = res_shift_c;
                    cout_d  = fa_cout_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final bit.
                    ovf_d   = carry_q ^ fa_cout_c;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset that aborts any addition.
    always_ff @(posedge clk_input) begin
        if (rst_input) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_output = busy_q;
    assign done_output = done_q;
    assign S_output    = s_q;
    assign Cout_output = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_output  = ovf_q;
`endif

endmodule : serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder built around the lab's 1-bit full adder cell. It captures two operands and a carry-in on a start pulse, then feeds them LSB-first through a single full adder, with one bit per clock. Carry is kept in a flip-flop and sum bits are collected in a shift register. Sits directly upstream of the full adder: it sequences the A/B/Cin stimulus that the combinational cell consumes, and assembles the cell's S/Cout results into a parallel word.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
clk_input  input  1  single clock; all state updates on rising edge
rst_input  input  1  reset, synchronous, active-high
start_input  input  1  request a new addition; sampled only in IDLE
A_input  input  WIDTH  operand A, captured on accepted start
B_input  input  WIDTH  operand B, captured on accepted start
Cin_input  input  1  carry-in, captured on accepted start
busy_output  output  1  high while bits are being shifted (state SHIFT)
done_output  output  1  one-cycle pulse: S_output/Cout_output just updated
S_output  output  WIDTH  registered sum, held until next completion
Cout_output  output  1  registered carry-out, held until next completion

Behaviour:
- Reset (rst_input=1 at an edge): state=IDLE, busy_output=0, done_output=0, S_output=0, Cout_output=0. Operand, result and carry registers and the bit counter are also cleared. Reset has priority over everything, including mid-operation: any addition in progress is aborted and no done pulse is produced.
- States: IDLE, SHIFT, DONE. Encoding: 2-bit, IDLE=0, SHIFT=1, DONE=2. Value 3 returns to IDLE.
- IDLE:
  - On an edge with start_input=1: a_sr<=A_input, b_sr<=B_input, carry<=Cin_input, cnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: on each edge:
  - sum = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - res_sr <= {sum, res_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one, zero-filled.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: S_output <= final shifted result, Cout_output <= final carry, go to DONE.
- DONE: done_output=1 for exactly this one cycle, busy_output=0. The next edge returns to IDLE unconditionally.
- Latency: start sampled at edge k gives done_output=1 during the cycle after edge k+WIDTH. The earliest next accepted start is at edge k+WIDTH+2.
- busy_output = (state==SHIFT); done_output = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- start_input in SHIFT or DONE is ignored and not queued. Changes on A/B/Cin after capture have no effect.
- Width rules:
  - The counter is clog2(WIDTH)+1 bits wide.
  - WIDTH=1: a single SHIFT cycle, and the result equals the full adder truth table.
  - Sum wraps modulo 2^WIDTH; the overflow bit appears only on Cout_output.

Optional Feature:
SERIAL_ADDER_OVF_EN:
- Defined: adds port ovf_output (output, 1 bit), the signed overflow flag.
  - Computed as the carry into the MSB XOR the carry out of the MSB.
  - Registered on the same edge as S_output and held with it; reset value 0.
  - Requires capturing the carry register value before the final bit is processed.
- Undefined: no ovf_output port and no extra registers. All other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg: state encoding constants (ST_IDLE, ST_SHIFT, ST_DONE), a state width constant of 2, and the default WIDTH.
- One sub-module, serial_fa_cell: the purely combinational 1-bit full adder (a, b, cin -> s, cout). It is instantiated once and drives the sum bit and next-carry.

Test Plan:
1. Hold rst_input=1 for 2 edges, then release -> S_output=0, Cout_output=0, busy_output=0, done_output=0, state IDLE.
2. WIDTH=4: A=0011, B=0101, Cin=0, start 1 cycle -> busy high for 4 cycles, then done high for 1 cycle; S_output=1000, Cout_output=0.
3. WIDTH=4: A=1111, B=0000, Cin=1 -> S_output=0000, Cout_output=1, and the result holds after done drops.
4. WIDTH=1: sweep all 8 combinations of {A, B, Cin} -> each {Cout_output, S_output} matches the full adder truth table (000->00, 001->01, 011->10, 111->11, etc.).
5. WIDTH=4:
   - Start A=0001, B=0001. Pulse start with A=1111 during SHIFT -> it is ignored; S_output=0010.
   - Separately, assert rst_input at the 2nd SHIFT cycle -> no done pulse and all outputs 0. A fresh start then completes normally.
6. SERIAL_ADDER_OVF_EN defined, WIDTH=4:
   - A=0111, B=0001, Cin=0 -> S_output=1000, Cout_output=0, ovf_output=1.
   - A=1111, B=0001 -> S_output=0000, Cout_output=1, ovf_output=0.
